// File: rtl/fc_serializer.sv
// fc_serializer: shifts a 48-bit function-control word MSB-first onto SIN
// under a generated SCLK and supervises the FC state machine's en.
module fc_serializer #(
    parameter int CLK_DIV    = 2,
    parameter int FC_WIDTH   = 48,
    parameter int EN_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic [FC_WIDTH-1:0] fc_data,
    input  logic                fc_en,
    output logic                write_fc,
    output logic                SCLK,
    output logic                SIN,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = (EN_TIMEOUT > 1) ? $clog2(EN_TIMEOUT) : 1;
    localparam logic [6:0] FIRST = 7'(64 - FC_WIDTH);
    localparam logic [6:0] LAST  = 7'd63;
    localparam logic [6:0] NEDGE = 7'd65;
    localparam logic [DW-1:0] DIV_TOP = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TMO_TOP = TW'(EN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        TRIG,
        SHIFT,
        WAIT_EN
    } state_t;

    state_t              state_q, state_d;
    logic [FC_WIDTH-1:0] sh_q, sh_d;
    logic [DW-1:0]       div_q, div_d;
    logic [6:0]          cnt_q, cnt_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                sclk_q, sclk_d;
    logic                sin_q, sin_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic run, wrap, rise, fall, en_chk, en_bad, last_fall;

    assign run       = (state_q == TRIG) || (state_q == SHIFT);
    assign wrap      = (div_q == DIV_TOP);
    assign rise      = run && wrap && !sclk_q;
    assign fall      = run && wrap && sclk_q;
    // en must be high from rising edge 1 through rising edge 64
    assign en_chk    = run && (cnt_q <= LAST) && (rise || cnt_q >= 7'd1);
    assign en_bad    = en_chk && !fc_en;
    assign last_fall = fall && (cnt_q == NEDGE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            sclk_q  <= 1'b0;
            sin_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            sclk_q  <= sclk_d;
            sin_q   <= sin_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        sclk_d  = sclk_q;
        sin_d   = sin_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = TRIG;
                    sh_d    = fc_data;
                    div_d   = '0;
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    sin_d   = 1'b0;
                end
            end
            TRIG, SHIFT: begin
                div_d = wrap ? '0 : div_q + 1'b1;
                if (wrap) sclk_d = !sclk_q;
                if (rise) cnt_d = cnt_q + 7'd1;
                if (fall) begin
                    if (cnt_q >= FIRST && cnt_q <= LAST) begin
                        sin_d = sh_q[FC_WIDTH-1];
                        sh_d  = {sh_q[FC_WIDTH-2:0], 1'b0};
                    end else begin
                        sin_d = 1'b0;
                    end
                end
                if (state_q == TRIG) state_d = SHIFT;
                if (last_fall) begin
                    state_d = WAIT_EN;
                    tmo_d   = '0;
                end
                if (en_bad) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    sclk_d  = 1'b0;
                    sin_d   = 1'b0;
                end
            end
            WAIT_EN: begin
                if (!fc_en) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tmo_q == TMO_TOP) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        write_fc = (state_q == TRIG);
        busy     = (state_q != IDLE);
        SCLK     = sclk_q;
        SIN      = sin_q;
        done     = done_q;
        error    = err_q;
    end

endmodule

// File: tb/tb_fc_serializer.sv
// Bench for fc_serializer: two instances (CLK_DIV=2 and 1) each with a
// behavioural FC state machine that raises en on write_fc and samples SIN.
module tb_fc_serializer;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [1:0]  start = '0;
    logic [47:0] fc_data [2];
    logic [1:0]  fc_en;
    logic [1:0]  write_fc, sclk, sin, busy, done, error;

    logic [1:0]  en_q = '0;
    logic [1:0]  kill = '0;
    logic [1:0]  hold = '0;

    int          cyc = 0;
    int          base = 0;
    int          checks = 0;
    int          errors = 0;

    int          rc [2];
    int          first_r [2];
    int          last_r [2];
    int          wf_n [2];
    int          out1 [2];
    logic [47:0] cap [2];
    logic [1:0]  sclk_p = '0;

    logic [47:0] exp_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign fc_en = en_q & ~kill;

    fc_serializer #(.CLK_DIV(2), .FC_WIDTH(48), .EN_TIMEOUT(16)) u_d2 (
        .clk(clk), .nrst(nrst), .start(start[0]), .fc_data(fc_data[0]),
        .fc_en(fc_en[0]), .write_fc(write_fc[0]), .SCLK(sclk[0]),
        .SIN(sin[0]), .busy(busy[0]), .done(done[0]), .error(error[0])
    );

    fc_serializer #(.CLK_DIV(1), .FC_WIDTH(48), .EN_TIMEOUT(16)) u_d1 (
        .clk(clk), .nrst(nrst), .start(start[1]), .fc_data(fc_data[1]),
        .fc_en(fc_en[1]), .write_fc(write_fc[1]), .SCLK(sclk[1]),
        .SIN(sin[1]), .busy(busy[1]), .done(done[1]), .error(error[1])
    );

    // FC state machine model: counts SCLK rising edges, captures SIN
    // on rising edges 17..64, drops en after falling edge 65
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            sclk_p[i] <= sclk[i];
            if (!nrst) begin
                en_q[i] <= 1'b0;
                rc[i]   <= 0;
            end else if (write_fc[i]) begin
                en_q[i]  <= 1'b1;
                rc[i]    <= 0;
                cap[i]   <= '0;
                out1[i]  <= 0;
                wf_n[i]  <= wf_n[i] + 1;
            end else if (sclk[i] && !sclk_p[i]) begin
                rc[i] <= rc[i] + 1;
                if (rc[i] == 0) first_r[i] <= cyc - base;
                last_r[i] <= cyc - base;
                if (rc[i] + 1 >= 17 && rc[i] + 1 <= 64)
                    cap[i] <= {cap[i][46:0], sin[i]};
                else if (sin[i])
                    out1[i] <= out1[i] + 1;
            end else if (!sclk[i] && sclk_p[i] && rc[i] == 65) begin
                if (!hold[i]) en_q[i] <= 1'b0;
            end
        end
    end

    task automatic start_xfer(input int i, input logic [47:0] d);
        @(negedge clk);
        fc_data[i] = d;
        start[i] = 1'b1;
        @(posedge clk);
        #1 base = cyc;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_rel(input int n);
        while (cyc - base < n) @(negedge clk);
    endtask

    task automatic finish_xfer(input int i, output int t_done,
                               output int t_err, output int nbusy);
        t_done = -1;
        t_err  = -1;
        nbusy  = 0;
        for (int k = 0; k < 1000 && t_done < 0 && t_err < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (busy[i]) nbusy++;
            if (done[i]) t_done = cyc - base;
            if (error[i]) t_err = cyc - base;
        end
    endtask

    task automatic test_reset;
        logic [11:0] outs;
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        outs = {write_fc, sclk, sin, busy, done, error};
        checks++;
        if (outs !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 000", outs);
        end
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        outs = {write_fc, sclk, sin, busy, done, error};
        checks++;
        if (outs !== 12'h000) begin
            errors++;
            $display("FAIL reset_release_idle: got %h want 000", outs);
        end
    endtask

    task automatic check_word(input int i, input string nm);
        logic [47:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: got empty queue want one entry", nm);
        end else begin
            e = exp_q.pop_front();
            if (cap[i] !== e) begin
                errors++;
                $display("FAIL %s_word: got %h want %h", nm, cap[i], e);
            end
        end
    endtask

    task automatic test_nominal;
        int td, te, nb, wf0;
        wf0 = wf_n[0];
        exp_q.push_back(48'hA5A5_0F0F_C3C3);
        start_xfer(0, 48'hA5A5_0F0F_C3C3);
        finish_xfer(0, td, te, nb);
        checks++;
        if (td !== 261) begin
            errors++;
            $display("FAIL nom_done_time: got %0d want 261", td);
        end
        checks++;
        if (te !== -1) begin
            errors++;
            $display("FAIL nom_no_error: got %0d want -1", te);
        end
        checks++;
        if (nb !== 261) begin
            errors++;
            $display("FAIL nom_busy_cycles: got %0d want 261", nb);
        end
        checks++;
        if (wf_n[0] - wf0 !== 1) begin
            errors++;
            $display("FAIL nom_write_fc_len: got %0d want 1", wf_n[0] - wf0);
        end
        checks++;
        if (rc[0] !== 65) begin
            errors++;
            $display("FAIL nom_rise_count: got %0d want 65", rc[0]);
        end
        checks++;
        if (first_r[0] !== 2 || last_r[0] !== 258) begin
            errors++;
            $display("FAIL nom_rise_times: got %0d..%0d want 2..258",
                     first_r[0], last_r[0]);
        end
        checks++;
        if (out1[0] !== 0) begin
            errors++;
            $display("FAIL nom_sin_outside: got %0d want 0", out1[0]);
        end
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL nom_busy_at_done: got %b want 0", busy[0]);
        end
        check_word(0, "nom");
        @(negedge clk);
        checks++;
        if (done[0] !== 1'b0) begin
            errors++;
            $display("FAIL nom_done_width: got %b want 0", done[0]);
        end
    endtask

    task automatic test_clkdiv1;
        int td, te, nb;
        exp_q.push_back(48'hFFFF_FFFF_FFFF);
        start_xfer(1, 48'hFFFF_FFFF_FFFF);
        finish_xfer(1, td, te, nb);
        checks++;
        if (td !== 131 || te !== -1) begin
            errors++;
            $display("FAIL div1_done: got done %0d err %0d want 131 -1", td, te);
        end
        checks++;
        if (rc[1] !== 65 || first_r[1] !== 1 || last_r[1] !== 129) begin
            errors++;
            $display("FAIL div1_edges: got %0d %0d..%0d want 65 1..129",
                     rc[1], first_r[1], last_r[1]);
        end
        checks++;
        if (out1[1] !== 0) begin
            errors++;
            $display("FAIL div1_sin_outside: got %0d want 0", out1[1]);
        end
        check_word(1, "div1");
    endtask

    task automatic test_ignore_start;
        int td, te, nb, nd, nbz;
        exp_q.push_back(48'h1234_5678_9ABC);
        start_xfer(0, 48'h1234_5678_9ABC);
        wait_rel(50);
        fc_data[0] = 48'hDEAD_BEEF_0001;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_rel(200);
        fc_data[0] = 48'h0F0F_F0F0_5555;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        finish_xfer(0, td, te, nb);
        checks++;
        if (td !== 261 || te !== -1) begin
            errors++;
            $display("FAIL ign_done: got done %0d err %0d want 261 -1", td, te);
        end
        check_word(0, "ign");
        nd = 0;
        nbz = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done[0]) nd++;
            if (busy[0]) nbz++;
        end
        checks++;
        if (nd !== 0 || nbz !== 0) begin
            errors++;
            $display("FAIL ign_extra: got done %0d busy %0d want 0 0", nd, nbz);
        end
    endtask

    task automatic test_en_drop;
        int td, te, nb;
        start_xfer(0, 48'h0000_FFFF_0000);
        wait_rel(40);
        kill[0] = 1'b1;
        finish_xfer(0, td, te, nb);
        checks++;
        if (te !== 41 || td !== -1) begin
            errors++;
            $display("FAIL drop_error: got err %0d done %0d want 41 -1", te, td);
        end
        checks++;
        if ({sclk[0], sin[0], busy[0], write_fc[0]} !== 4'b0000) begin
            errors++;
            $display("FAIL drop_outputs: got %b want 0000",
                     {sclk[0], sin[0], busy[0], write_fc[0]});
        end
        kill[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (error[0] !== 1'b0 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL drop_pulse: got err %b done %b want 0 0",
                     error[0], done[0]);
        end
    endtask

    task automatic test_timeout;
        int td, te, nb;
        hold[0] = 1'b1;
        start_xfer(0, 48'h8000_0000_0001);
        finish_xfer(0, td, te, nb);
        checks++;
        if (te !== 276 || td !== -1) begin
            errors++;
            $display("FAIL tmo_error: got err %0d done %0d want 276 -1", te, td);
        end
        hold[0] = 1'b0;
        exp_q.push_back(48'h8000_0000_0001);
        start_xfer(0, 48'h8000_0000_0001);
        finish_xfer(0, td, te, nb);
        checks++;
        if (td !== 261 || te !== -1) begin
            errors++;
            $display("FAIL tmo_retry: got done %0d err %0d want 261 -1", td, te);
        end
        check_word(0, "tmo");
    endtask

    task automatic test_reset_mid;
        logic [5:0] outs;
        int nb;
        start_xfer(0, 48'hFFFF_0000_FFFF);
        wait_rel(100);
        #2 nrst = 1'b0;
        #1;
        outs = {sclk[0], sin[0], busy[0], write_fc[0], done[0], error[0]};
        checks++;
        if (outs !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset_async: got %b want 000000", outs);
        end
        @(negedge clk);
        nrst = 1'b1;
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy[0] || done[0] || error[0] || sclk[0]) nb++;
        end
        checks++;
        if (nb !== 0) begin
            errors++;
            $display("FAIL mid_reset_idle: got %0d active cycles want 0", nb);
        end
    endtask

    initial begin
        fc_data[0] = '0;
        fc_data[1] = '0;
        for (int i = 0; i < 2; i++) begin
            rc[i] = 0;
            first_r[i] = 0;
            last_r[i] = 0;
            wf_n[i] = 0;
            out1[i] = 0;
            cap[i] = '0;
        end
        test_reset();
        test_nominal();
        test_clkdiv1();
        test_ignore_start();
        test_en_drop();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_serializer.md
Name: fc_serializer

Overview:
Upstream companion of the FC state machine for the LED band drivers. On a start request it captures a 48-bit function-control word, pulses write_fc, and generates SCLK. It then shifts the word MSB-first onto SIN, aligned with the FCWRTEN/WRTFC LAT window that the FC state machine produces from the same SCLK. It supervises the FC state machine's en and reports done or error to the top-level LED controller.

Parameters:
CLK_DIV, 2, clk cycles per SCLK half-period (>=1)
FC_WIDTH, 48, FC word length in bits (fixed by the driver protocol; only 48 is supported)
EN_TIMEOUT, 16, clk cycles allowed for en to fall after the last SCLK falling edge

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
start  in  1  one-clk request to write a new FC word; ignored while busy
fc_data  in  FC_WIDTH  FC word, sampled on an accepted start
fc_en  in  1  en from the FC state machine
write_fc  out  1  one-clk trigger to the FC state machine
SCLK  out  1  shift clock to the drivers and to the FC state machine
SIN  out  1  serial FC data, changes only on SCLK falling edges
busy  out  1  high from the cycle after start is accepted until done/error
done  out  1  one-clk pulse: word written, en released
error  out  1  one-clk pulse: en protocol violation, transfer aborted

Behaviour:
- Reset (async, nrst=0): state IDLE. write_fc, SCLK, SIN, busy, done and error are all 0. Shift register, edge counter and divider are cleared. Reset mid-transfer aborts immediately with SCLK low; no done or error pulse.
- States: IDLE -> TRIG -> SHIFT -> WAIT_EN -> IDLE.
- IDLE: when start=1 at clk edge 0, capture fc_data, then write_fc=1 and busy=1 during cycle 0..1 (state TRIG, one clk).
- SHIFT: divider counts 0..CLK_DIV-1 from edge 0 and toggles SCLK on wrap.
  - Rising edge k (k=1..65) occurs at clk edge CLK_DIV*(2k-1).
  - Falling edge k occurs at clk edge CLK_DIV*2k.
  - Edge counter increments on each rising edge.
- SIN: 0 until falling edge 16.
  - After falling edge k (16<=k<=63), SIN = fc_data[63-k]. So bit 47 is valid for rising edge 17 and bit 0 for rising edge 64.
  - SIN returns to 0 after falling edge 64.
  - Consequence: 48 data bits on rising edges 17..64, which coincide with the FC state machine's counter values 16..63. WRTFC LAT covers rising edges 60..64.
- After falling edge 65, SCLK stays low and the state moves to WAIT_EN.
- WAIT_EN: when fc_en=0, pulse done for one clk, clear busy, go to IDLE. Nominally this is the cycle right after falling edge 65.
- Error checks (each one: pulse error for one clk, SCLK=0, SIN=0, busy=0, go to IDLE):
  - fc_en=0 at any clk edge from rising edge 1 through rising edge 64.
  - fc_en still 1 EN_TIMEOUT clks after entering WAIT_EN.
- start while busy: ignored; the captured word is not modified. start in the same cycle as done: ignored (accepted only in IDLE).
- done and error are mutually exclusive. write_fc is never high outside TRIG.

Test Plan:
- Reset: nrst=0 mid-SHIFT at clk 100 -> SCLK, SIN, busy, write_fc, done, error all 0 asynchronously. After release: IDLE, no pulses.
- Nominal write, CLK_DIV=2, fc_data=48'hA5A5_0F0F_C3C3, FC state machine attached -> write_fc high for exactly 1 clk; 65 SCLK rising edges at clk 2,6,...,258; bits captured on rising edges 17..64 equal 0xA5A50F0FC3C3 MSB-first; LAT high on rising edges 2..16 and 60..64; done pulse at clk 261; busy high clk 1..261.
- CLK_DIV=1 with fc_data=48'hFFFF_FFFF_FFFF -> SCLK toggles every clk; FC state machine still counts 65 edges; SIN=1 exactly for rising edges 17..64; done asserted.
- start pulsed at clk 50 and clk 200 during a transfer with different fc_data -> ignored; shifted word unchanged; only one done.
- fc_en forced low at clk 40 -> error pulse next clk, SCLK low, busy 0, no done.
- fc_en held high after falling edge 65 -> error exactly 16 clks after WAIT_EN entry; a following start then completes normally.
